act_scheduler: RTL and testbench
================================

Name: act_scheduler

Overview:
- Shares one ActivationUnit instance (8-bit in, registered 8-bit out) among N accumulator-column requesters of the MAC array.
- Arbitrates requesters round-robin and drives the unit's data_in.
- Tracks in-flight operands through the unit's fixed latency and buffers tagged results in an output FIFO with valid/ready backpressure.
- Provides run/flush sequencing so the top-level controller can drain the activation stage between tiles.

Parameters:
- N, 4, number of requesters (2..8)
- ACT_LAT, 1, ActivationUnit latency in cycles from data_in sample edge to data_out update (≥1)
- FIFO_DEPTH, 4, output result buffer depth; must be ≥ ACT_LAT+2 for one result per cycle

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  start/allow scheduling
- flush  in  1  request drain, sampled in RUN
- flush_done  out  1  one-cycle pulse when drain completes
- req_valid  in  N  per-requester operand valid
- req_data  in  8*N  per-requester operand; requester i occupies bits [8i+7:8i]
- req_ready  out  N  one-hot grant; transfer when req_valid[i]&req_ready[i]
- act_data_in  out  8  to ActivationUnit data_in
- act_data_out  in  8  from ActivationUnit data_out
- out_valid  out  1  result available
- out_data  out  8  activated result
- out_id  out  clog2(N)  originating requester index
- out_ready  in  1  consumer accepts; pop when out_valid&out_ready

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; rr pointer=N-1, so requester 0 has first priority.
  - In-flight tag pipeline, FIFO, counters and the flush_done register cleared.
  - Outputs: req_ready=0, act_data_in=0, out_valid=0, out_data=0, out_id=0, flush_done=0.
  - Reset mid-operation drops all in-flight and buffered results; no output follows.
- FSM states are IDLE, RUN and DRAIN.
  - IDLE: no grants. en=1 → RUN.
  - RUN: grants allowed. flush=1 → DRAIN, and no grant is issued in that cycle. en=0 with flush=0 stays in RUN.
  - DRAIN: no grants. When in-flight count=0 and the FIFO is empty → flush_done=1 for one cycle, then IDLE.
  - flush has priority over en.
- Grant (combinational, from registered state):
  - Issue permitted when state=RUN and inflight_cnt+fifo_cnt < FIFO_DEPTH. The count uses registered values only, so a same-cycle pop is not credited.
  - Winner is the first asserted req_valid scanning upward from pointer+1 with wrap-around. req_ready is one-hot of the winner, or all-zero.
  - req_ready[i] does not wait for req_valid[i] to be sampled by any other path; it depends only on state, credit and req_valid.
  - On transfer, the pointer updates to the winner index. Without a transfer the pointer holds.
- act_data_in = the winner's req_data slice when a transfer occurs, else 0. It is combinational; the ActivationUnit samples it at the transfer edge.
- Tag pipeline: an ACT_LAT-stage shift register of {valid, id}, loaded at the transfer edge. When the last stage is valid, {act_data_out, id} is pushed into the FIFO at the next edge.
- Latency: transfer at edge k → out_valid=1 after edge k+ACT_LAT+1 (2 cycles at ACT_LAT=1) if the FIFO was empty.
- FIFO behaviour:
  - out_data and out_id present the head entry; out_valid = not empty.
  - Simultaneous push and pop keeps the count.
  - The credit rule guarantees no overflow. Push when full is an assertion failure in simulation.
  - Pop when empty is ignored.
- Throughput: one result per cycle sustained when out_ready=1 and FIFO_DEPTH ≥ ACT_LAT+2.
- Ordering: results exit in issue order.

Optional Feature:
- Macro: ACT_SCHED_PERF_CNT_EN.
- Defined: adds ports busy_cycles (out 32) and stall_cycles (out 32), both reset to 0.
  - busy_cycles increments each cycle a transfer occurs.
  - stall_cycles increments each cycle in RUN with any req_valid set and no grant because of credit.
  - Both saturate at 2^32-1 and clear only on rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package act_sched_pkg contains:
  - state typedef (IDLE, RUN, DRAIN)
  - DATA_W=8
  - function id_width(N)=clog2(N), minimum 1
- Sub-module rr_arbiter (parameter N) handles round-robin arbitration:
  - inputs: req, pointer, enable
  - outputs: one-hot grant and encoded index
- FIFO and tag pipeline stay inline.

Test Plan:
- Reset then en=1, requester 0 only, data=12 → req_ready=0001 at the first RUN cycle; out_valid two cycles after transfer with out_data=act_unit(12), out_id=0.
- All four requesters valid continuously, out_ready=1, data i=10+i → grant order 0,1,2,3,0… and out_id sequence 0,1,2,3 at one result per cycle.
- out_ready=0, all valid → exactly FIFO_DEPTH transfers then req_ready=0000 (stall_cycles counting if enabled); out_ready=1 → grants resume, no loss or duplication.
- Requesters 1,3 valid with pointer=1 → grant 3, then 1, then 3 (wrap-around).
- Three results in flight/buffered, flush=1 → no further grants; flush_done pulses once after the last pop; state IDLE; a new en=1 restarts with the preserved pointer.
- rst=1 asserted while two results are in flight → all outputs 0 immediately; after release no stale out_valid appears; data 255 then produces act_unit(255) with correct id.

Source files
------------

// File: rtl/act_sched_pkg.sv
// Shared types and sizing helpers for the activation-unit scheduler.
// No logic; imported by the arbiter and the scheduler top.
package act_sched_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    function automatic int id_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/act_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request above ptr_i (wrapping), combinational.
// Zero latency; en_i=0 forces no grant, which is how the caller applies credit backpressure.
module rr_arbiter
    import act_sched_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IDW = id_width(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    input  logic           en_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] idx_o
);

    logic           found;
    logic [IDW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        // Offset starts at 1 so the last winner has lowest priority.
        for (int off = 1; off <= N; off++) begin
            cand = IDW'((int'(ptr_i) + off) % N);
            if (en_i && !found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/act_scheduler.sv
// Shares one ActivationUnit among N requesters; result out_valid ACT_LAT+1 cycles after a transfer cycle.
// Grants stop when in-flight plus buffered results reach FIFO_DEPTH; ACT_SCHED_PERF_CNT_EN adds busy/stall counters.
module act_scheduler
    import act_sched_pkg::*;
#(
    parameter  int N          = 4,
    parameter  int ACT_LAT    = 1,
    parameter  int FIFO_DEPTH = 4,
    localparam int IDW        = id_width(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                flush,
    output logic                flush_done,
    input  logic [N-1:0]        req_valid,
    input  logic [DATA_W*N-1:0] req_data,
    output logic [N-1:0]        req_ready,
    output logic [DATA_W-1:0]   act_data_in,
    input  logic [DATA_W-1:0]   act_data_out,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [IDW-1:0]      out_id,
    input  logic                out_ready
`ifdef ACT_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]         busy_cycles,
    output logic [31:0]         stall_cycles
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    sched_state_t   state_q;
    logic           flush_done_q;
    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] win_idx;
    logic           credit_ok;
    logic           arb_en;
    logic           xfer;
    logic           push;
    logic           pop;

    logic [CW-1:0]  inflight_cnt_q, inflight_cnt_d;
    logic [CW-1:0]  fifo_cnt_q, fifo_cnt_d;

    logic [ACT_LAT-1:0] tag_vld_q;
    logic [IDW-1:0]     tag_id_q [ACT_LAT];

    logic [DATA_W-1:0]  fifo_dat_q [FIFO_DEPTH];
    logic [IDW-1:0]     fifo_id_q  [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Registered counts only: a pop in this cycle frees credit next cycle.
    assign credit_ok = ({1'b0, inflight_cnt_q} + {1'b0, fifo_cnt_q}) < (CW + 1)'(FIFO_DEPTH);
    assign arb_en    = (state_q == RUN) && !flush && credit_ok;

    rr_arbiter #(.N(N)) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .en_i  (arb_en),
        .gnt_o (req_ready),
        .idx_o (win_idx)
    );

    assign xfer        = |req_ready;
    assign act_data_in = xfer ? req_data[int'(win_idx) * DATA_W +: DATA_W] : '0;
    assign push        = tag_vld_q[ACT_LAT-1];
    assign pop         = out_valid && out_ready;

    assign inflight_cnt_d = inflight_cnt_q + CW'(xfer) - CW'(push);
    assign fifo_cnt_d     = fifo_cnt_q + CW'(push) - CW'(pop);

    assign out_valid  = (fifo_cnt_q != '0);
    assign out_data   = fifo_dat_q[rd_ptr_q];
    assign out_id     = fifo_id_q[rd_ptr_q];
    assign flush_done = flush_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            case (state_q)
                IDLE:    if (en) state_q <= RUN;
                RUN:     if (flush) state_q <= DRAIN;
                DRAIN: begin
                    if (inflight_cnt_q == '0 && fifo_cnt_q == '0) begin
                        flush_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= IDW'(N - 1);
        end else if (xfer) begin
            rr_ptr_q <= win_idx;
        end
    end

    // Tag pipeline mirrors the ActivationUnit latency so each output byte gets its requester id.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_q      <= '0;
            inflight_cnt_q <= '0;
            for (int i = 0; i < ACT_LAT; i++) tag_id_q[i] <= '0;
        end else begin
            tag_vld_q[0]   <= xfer;
            tag_id_q[0]    <= win_idx;
            inflight_cnt_q <= inflight_cnt_d;
            for (int i = 1; i < ACT_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_dat_q[i] <= '0;
                fifo_id_q[i]  <= '0;
            end
        end else begin
            fifo_cnt_q <= fifo_cnt_d;
            if (push) begin
                fifo_dat_q[wr_ptr_q] <= act_data_out;
                fifo_id_q[wr_ptr_q]  <= tag_id_q[ACT_LAT-1];
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) assert (!(push && fifo_cnt_q == CW'(FIFO_DEPTH)));
    end

`ifdef ACT_SCHED_PERF_CNT_EN
    logic [31:0] busy_q;
    logic [31:0] stall_q;
    logic        stall_now;

    assign stall_now = (state_q == RUN) && (|req_valid) && !credit_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            stall_q <= '0;
        end else begin
            if (xfer && busy_q != '1)       busy_q  <= busy_q + 32'd1;
            if (stall_now && stall_q != '1) stall_q <= stall_q + 32'd1;
        end
    end

    assign busy_cycles  = busy_q;
    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_act_scheduler.sv
// Directed bench for act_scheduler with a behavioural 1-cycle ActivationUnit (x ^ 0xA5).
module tb_act_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [7:0]  act_data_out = '0;
    logic        flush_done;
    logic [3:0]  req_ready;
    logic [7:0]  act_data_in;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
`ifdef ACT_SCHED_PERF_CNT_EN
    logic [31:0] busy_cycles;
    logic [31:0] stall_cycles;
`endif

    act_scheduler #(.N(4), .ACT_LAT(1), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .flush        (flush),
        .flush_done   (flush_done),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .act_data_in  (act_data_in),
        .act_data_out (act_data_out),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_id       (out_id),
        .out_ready    (out_ready)
`ifdef ACT_SCHED_PERF_CNT_EN
        ,
        .busy_cycles  (busy_cycles),
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] act_fn(input logic [7:0] x);
        return x ^ 8'hA5;
    endfunction

    always @(posedge clk) act_data_out <= act_fn(act_data_in);

    int         total = 0;
    int         bad = 0;
    int         model_ptr = 3;
    int         xfer_cnt = 0;
    bit         sb_on = 1'b0;
    logic [9:0] sbq [$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int off = 1; off <= 4; off++) begin
            if (v[(p + off) % 4]) return (p + off) % 4;
        end
        return -1;
    endfunction

    // Sample on the falling edge; scoreboard tracks grants and pops when enabled.
    task automatic samp();
        int         w;
        logic [9:0] e;
        @(negedge clk);
        if (sb_on) begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_without_expected got=%0h/%0d exp=none", out_data, out_id);
                end else begin
                    e = sbq.pop_front();
                    chk("out_data", {24'd0, out_data}, {24'd0, e[9:2]});
                    chk("out_id", {30'd0, out_id}, {30'd0, e[1:0]});
                end
            end
            if (req_ready != 4'd0) begin
                w = rr_pick(req_valid, model_ptr);
                if (w < 0) begin
                    total++;
                    bad++;
                    $display("FAIL grant_without_valid got=%0h exp=0", req_ready);
                end else begin
                    chk("grant", {28'd0, req_ready}, 32'd1 << w);
                    chk("act_in", {24'd0, act_data_in}, {24'd0, req_data[8*w +: 8]});
                    sbq.push_back({act_fn(req_data[8*w +: 8]), 2'(w)});
                    model_ptr = w;
                    xfer_cnt++;
                end
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int ov_seen;
        req_valid = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && sbq.size() != 0; i++) begin
            samp();
            adv();
        end
        chk("drain_left", sbq.size(), 0);
        ov_seen = 0;
        repeat (3) begin
            samp();
            if (out_valid) ov_seen++;
            adv();
        end
        chk("no_stale_out", ov_seen, 0);
    endtask

    typedef struct {
        logic        rst, en, flush, ordy;
        logic [3:0]  vld;
        logic [31:0] dat;
        logic [3:0]  x_rdy;
        logic [7:0]  x_act;
        logic        x_ov;
        logic [7:0]  x_od;
        logic [1:0]  x_oid;
    } vec_t;

    vec_t tbl [16];

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] wexp [3];
        logic [3:0] fexp [3];
        logic [3:0] last_rdy;
        logic       last_ov;
        int         x0, pulses, fd_early, rdy_seen, ov_seen;

        // rst, en, flush, ordy, vld, data | ready, act_in, out_valid, out_data, out_id
        tbl[0]  = '{1, 0, 0, 0, 4'h0, 32'h0000000C, 4'h0, 8'd0,  0, 8'h00, 2'd0};
        tbl[1]  = '{0, 1, 0, 0, 4'h1, 32'h0000000C, 4'h0, 8'd0,  0, 8'h00, 2'd0};
        tbl[2]  = '{0, 1, 0, 0, 4'h1, 32'h0000000C, 4'h1, 8'd12, 0, 8'h00, 2'd0};
        tbl[3]  = '{0, 1, 0, 0, 4'h0, 32'h0000000C, 4'h0, 8'd0,  0, 8'h00, 2'd0};
        tbl[4]  = '{0, 1, 0, 1, 4'h0, 32'h0000000C, 4'h0, 8'd0,  1, 8'hA9, 2'd0};
        tbl[5]  = '{0, 1, 0, 1, 4'h0, 32'h0000000C, 4'h0, 8'd0,  0, 8'h00, 2'd0};
        tbl[6]  = '{1, 1, 0, 0, 4'h0, 32'h0D0C0B0A, 4'h0, 8'd0,  0, 8'h00, 2'd0};
        tbl[7]  = '{0, 1, 0, 1, 4'hF, 32'h0D0C0B0A, 4'h0, 8'd0,  0, 8'h00, 2'd0};
        tbl[8]  = '{0, 1, 0, 1, 4'hF, 32'h0D0C0B0A, 4'h1, 8'd10, 0, 8'h00, 2'd0};
        tbl[9]  = '{0, 1, 0, 1, 4'hF, 32'h0D0C0B0A, 4'h2, 8'd11, 0, 8'h00, 2'd0};
        tbl[10] = '{0, 1, 0, 1, 4'hF, 32'h0D0C0B0A, 4'h4, 8'd12, 1, 8'hAF, 2'd0};
        tbl[11] = '{0, 1, 0, 1, 4'hF, 32'h0D0C0B0A, 4'h8, 8'd13, 1, 8'hAE, 2'd1};
        tbl[12] = '{0, 1, 0, 1, 4'hF, 32'h0D0C0B0A, 4'h1, 8'd10, 1, 8'hA9, 2'd2};
        tbl[13] = '{0, 1, 0, 1, 4'h0, 32'h0D0C0B0A, 4'h0, 8'd0,  1, 8'hA8, 2'd3};
        tbl[14] = '{0, 1, 0, 1, 4'h0, 32'h0D0C0B0A, 4'h0, 8'd0,  1, 8'hAF, 2'd0};
        tbl[15] = '{0, 1, 0, 1, 4'h0, 32'h0D0C0B0A, 4'h0, 8'd0,  0, 8'h00, 2'd0};

        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            rst       = tbl[i].rst;
            en        = tbl[i].en;
            flush     = tbl[i].flush;
            out_ready = tbl[i].ordy;
            req_valid = tbl[i].vld;
            req_data  = tbl[i].dat;
            samp();
            chk($sformatf("r%0d_ready", i), {28'd0, req_ready}, {28'd0, tbl[i].x_rdy});
            chk($sformatf("r%0d_act_in", i), {24'd0, act_data_in}, {24'd0, tbl[i].x_act});
            chk($sformatf("r%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].x_ov});
            if (tbl[i].x_ov || tbl[i].rst) begin
                chk($sformatf("r%0d_out_data", i), {24'd0, out_data}, {24'd0, tbl[i].x_od});
                chk($sformatf("r%0d_out_id", i), {30'd0, out_id}, {30'd0, tbl[i].x_oid});
            end
            if (tbl[i].rst) chk($sformatf("r%0d_flush_done", i), {31'd0, flush_done}, 32'd0);
            adv();
        end

        // Backpressure: exactly FIFO_DEPTH transfers, then no grants until pops.
        sb_on     = 1'b1;
        model_ptr = 0;
        req_data  = 32'h17161514;
        req_valid = 4'hF;
        out_ready = 1'b0;
        x0        = xfer_cnt;
        last_rdy  = '0;
        last_ov   = 1'b0;
        repeat (8) begin
            samp();
            last_rdy = req_ready;
            last_ov  = out_valid;
            adv();
        end
        chk("bp_xfers", xfer_cnt - x0, 4);
        chk("bp_stalled_ready", {28'd0, last_rdy}, 32'd0);
        chk("bp_out_valid", {31'd0, last_ov}, 32'd1);
        out_ready = 1'b1;
        x0        = xfer_cnt;
        repeat (6) begin
            samp();
            adv();
        end
        chk("bp_resumed", (xfer_cnt - x0) > 0, 1);
        drain();

        // Wrap-around: pointer parked at 1, requesters 1 and 3 alternate starting with 3.
        req_data  = 32'h21201F1E;
        req_valid = 4'b0010;
        samp();
        chk("wrap_pre", {28'd0, req_ready}, 32'h2);
        adv();
        wexp      = '{4'h8, 4'h2, 4'h8};
        req_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            samp();
            chk($sformatf("wrap_%0d", i), {28'd0, req_ready}, {28'd0, wexp[i]});
            adv();
        end
        drain();

        // Flush with three results buffered.
        req_data  = 32'h2B2A2928;
        req_valid = 4'hF;
        out_ready = 1'b0;
        fexp      = '{4'h1, 4'h2, 4'h4};
        for (int i = 0; i < 3; i++) begin
            samp();
            chk($sformatf("pre_flush_%0d", i), {28'd0, req_ready}, {28'd0, fexp[i]});
            adv();
        end
        flush = 1'b1;
        samp();
        chk("flush_cycle_nogrant", {28'd0, req_ready}, 32'd0);
        adv();
        flush    = 1'b0;
        en       = 1'b0;
        rdy_seen = 0;
        pulses   = 0;
        repeat (3) begin
            samp();
            if (req_ready != 4'd0) rdy_seen++;
            if (flush_done) pulses++;
            adv();
        end
        chk("drain_hold_early_done", pulses, 0);
        out_ready = 1'b1;
        fd_early  = 0;
        repeat (12) begin
            samp();
            if (flush_done) begin
                pulses++;
                if (sbq.size() != 0) fd_early++;
            end
            if (req_ready != 4'd0) rdy_seen++;
            adv();
        end
        chk("flush_done_pulses", pulses, 1);
        chk("flush_done_before_pop", fd_early, 0);
        chk("drain_grants", rdy_seen, 0);
        chk("flush_q_empty", sbq.size(), 0);
        en = 1'b1;
        samp();
        chk("restart_idle", {28'd0, req_ready}, 32'd0);
        adv();
        samp();
        chk("restart_ptr", {28'd0, req_ready}, 32'h8);
        adv();
        out_ready = 1'b0;
        samp();
        adv();

        // Asynchronous reset with two results outstanding.
        rst = 1'b1;
        #2;
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_act_in", {24'd0, act_data_in}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_id", {30'd0, out_id}, 32'd0);
        chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
        sbq.delete();
        model_ptr = 3;
        adv();
        rst       = 1'b0;
        en        = 1'b1;
        req_valid = '0;
        out_ready = 1'b1;
        ov_seen   = 0;
        repeat (5) begin
            samp();
            if (out_valid) ov_seen++;
            adv();
        end
        chk("post_rst_stale", ov_seen, 0);
        req_data  = 32'h00FF0000;
        req_valid = 4'b0100;
        samp();
        chk("post_rst_grant", {28'd0, req_ready}, 32'h4);
        adv();
        drain();
`ifdef ACT_SCHED_PERF_CNT_EN
        chk("busy_cycles", busy_cycles, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
